// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural integer register file.
// It selects the write-back result from the MEM/WB outputs and commits it to
// x1..x31. It serves two decode read ports with write-first bypass, exports the
// result and the effective write enable to the forwarding unit, and counts
// retired instructions.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   PC_plus4, alu_out, read_data  write-back candidates from MEM/WB
//   addD, RegWrite, ResultSrc     destination index, write enable, result select
//   wb_valid                      1 = real instruction, 0 = bubble
//   addA, addB                    decode read indices (rs1, rs2)
//   dataA, dataB                  read data (combinational, bypassed)
//   result, wb_we                 selected value / effective write (combinational)
//   instret                       retired-instruction count (registered)
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC_plus4,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] read_data,
  input  logic [4:0]        addD,
  input  logic              RegWrite,
  input  logic [1:0]        ResultSrc,
  input  logic              wb_valid,
  input  logic [4:0]        addA,
  input  logic [4:0]        addB,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic [DATA_W-1:0] result,
  output logic              wb_we,
  output logic [CNT_W-1:0]  instret
);

  localparam int unsigned NREGS = 32;

  // x0 is hardwired to zero, so only x1..x31 hold state
  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [CNT_W-1:0]  instret_q;
  logic [CNT_W-1:0]  instret_d;

  // Result select; the reserved encoding falls back to the ALU result
  always_comb begin
    result = alu_out;
    case (ResultSrc)
      2'b01:   result = read_data;
      2'b10:   result = PC_plus4;
      default: result = alu_out;
    endcase
  end

  // Bubbles and writes to x0 neither store nor bypass
  assign wb_we = wb_valid & RegWrite & (addD != 5'd0);

  // Read port A: zero for x0, write-first bypass, else storage
  always_comb begin
    dataA = '0;
    if (addA == 5'd0)
      dataA = '0;
    else if (wb_we && (addA == addD))
      dataA = result;
    else
      dataA = regs_q[addA];
  end

  // Read port B: identical policy to port A
  always_comb begin
    dataB = '0;
    if (addB == 5'd0)
      dataB = '0;
    else if (wb_we && (addB == addD))
      dataB = result;
    else
      dataB = regs_q[addB];
  end

  // Register storage; a write in flight when rst asserts is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we) begin
      regs_q[addD] <= result;
    end
  end

  // Every valid instruction retires, whether or not it writes a register
  always_comb begin
    instret_d = instret_q;
    if (wb_valid)
      instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instret_q <= '0;
    else
      instret_q <= instret_d;
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, result mux, bypass, x0, bubble, wrap.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] PC_plus4;
  logic [31:0] alu_out;
  logic [31:0] read_data;
  logic [4:0]  addD;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic        wb_valid;
  logic [4:0]  addA;
  logic [4:0]  addB;
  logic [31:0] dataA, dataB, result;
  logic        wb_we;
  logic [63:0] instret;

  // Narrow-counter instance, shares all inputs with the main one
  logic [31:0] dataA4, dataB4, result4;
  logic        wb_we4;
  logic [3:0]  instret4;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [63:0] exp_ret;
  logic [31:0] model [1:31];
  logic [31:0] mux_exp [4];

  wb_regfile #(.DATA_W(32), .CNT_W(64)) u_dut (
    .clk(clk), .rst(rst), .PC_plus4(PC_plus4), .alu_out(alu_out),
    .read_data(read_data), .addD(addD), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .wb_valid(wb_valid), .addA(addA), .addB(addB),
    .dataA(dataA), .dataB(dataB), .result(result), .wb_we(wb_we),
    .instret(instret)
  );

  wb_regfile #(.DATA_W(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .PC_plus4(PC_plus4), .alu_out(alu_out),
    .read_data(read_data), .addD(addD), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .wb_valid(wb_valid), .addA(addA), .addB(addB),
    .dataA(dataA4), .dataB(dataB4), .result(result4), .wb_we(wb_we4),
    .instret(instret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_ret  = '0;
    mux_exp[0] = 32'h11; mux_exp[1] = 32'h22;
    mux_exp[2] = 32'h33; mux_exp[3] = 32'h11;
    rst = 1'b1;
    PC_plus4 = '0; alu_out = '0; read_data = '0;
    addD = '0; RegWrite = 1'b0; ResultSrc = 2'b00; wb_valid = 1'b0;
    addA = 5'd5; addB = 5'd9;

    // Power-on reset state
    #2;
    check("por_dataA", 64'(dataA), 64'h0);
    check("por_instret", instret, 64'h0);
    check("por_instret4", 64'(instret4), 64'h0);
    @(negedge clk) rst = 1'b0;

    // Load random contents into x1..x31
    for (int i = 1; i < 32; i++) begin
      model[i]  = $urandom | 32'h1;
      addD      = 5'(i);
      alu_out   = model[i];
      RegWrite  = 1'b1;
      wb_valid  = 1'b1;
      @(negedge clk);
      exp_ret++;
    end
    wb_valid = 1'b0;
    RegWrite = 1'b0;
    #1;
    check("load_x5", 64'(dataA), 64'(model[5]));
    check("load_x9", 64'(dataB), 64'(model[9]));
    check("load_instret", instret, exp_ret);

    // Async reset pulse with no clock edge in between
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_x5", 64'(dataA), 64'h0);
    check("arst_instret", instret, 64'h0);
    exp_ret = '0;
    for (int i = 1; i < 32; i++) begin
      addA = 5'(i);
      #1;
      check("arst_sweep", 64'(dataA), 64'h0);
    end

    // First write after release lands normally
    @(negedge clk);
    rst = 1'b0;
    addD = 5'd2; alu_out = 32'h0000CAFE; ResultSrc = 2'b00;
    RegWrite = 1'b1; wb_valid = 1'b1; addA = 5'd2;
    @(posedge clk);
    #1 wb_valid = 1'b0;
    exp_ret++;
    #1;
    check("post_rst_write", 64'(dataA), 64'h0000CAFE);
    check("post_rst_instret", instret, exp_ret);

    // Result mux through x5
    addD = 5'd5; alu_out = 32'h11; read_data = 32'h22; PC_plus4 = 32'h33;
    addA = 5'd5;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      ResultSrc = 2'(s); wb_valid = 1'b1; RegWrite = 1'b1;
      #1;
      check("mux_result", 64'(result), 64'(mux_exp[s]));
      @(posedge clk);
      #1 wb_valid = 1'b0;
      exp_ret++;
      #1;
      check("mux_stored", 64'(dataA), 64'(mux_exp[s]));
    end

    // Same-cycle bypass on both ports
    @(negedge clk);
    addA = 5'd7; addB = 5'd7; addD = 5'd7; alu_out = 32'hDEADBEEF;
    ResultSrc = 2'b00; RegWrite = 1'b1; wb_valid = 1'b1;
    #1;
    check("byp_A_pre", 64'(dataA), 64'hDEADBEEF);
    check("byp_B_pre", 64'(dataB), 64'hDEADBEEF);
    check("byp_we", 64'(wb_we), 64'h1);
    @(posedge clk);
    #1 wb_valid = 1'b0;
    exp_ret++;
    #1;
    check("byp_A_post", 64'(dataA), 64'hDEADBEEF);
    check("byp_B_post", 64'(dataB), 64'hDEADBEEF);

    // Write to x0 is discarded but still retires
    @(negedge clk);
    addD = 5'd0; alu_out = 32'hFFFFFFFF; RegWrite = 1'b1; wb_valid = 1'b1;
    addA = 5'd0;
    #1;
    check("x0_result", 64'(result), 64'hFFFFFFFF);
    check("x0_dataA_pre", 64'(dataA), 64'h0);
    check("x0_we_pre", 64'(wb_we), 64'h0);
    @(posedge clk);
    exp_ret++;
    #1;
    check("x0_dataA_post", 64'(dataA), 64'h0);
    check("x0_we_post", 64'(wb_we), 64'h0);
    check("x0_instret", instret, exp_ret);

    // Bubble: no write, no bypass, no increment
    @(negedge clk);
    wb_valid = 1'b0; RegWrite = 1'b1; addD = 5'd3; alu_out = 32'hAA; addA = 5'd3;
    #1;
    check("bub_we", 64'(wb_we), 64'h0);
    check("bub_dataA_pre", 64'(dataA), 64'h0);
    @(posedge clk);
    #1;
    check("bub_dataA_post", 64'(dataA), 64'h0);
    check("bub_instret", instret, exp_ret);

    // Counter wrap on the 4-bit instance
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    check("wrap_start", 64'(instret4), 64'h0);
    RegWrite = 1'b0; wb_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      check("wrap_cnt", 64'(instret4), 64'(i % 16));
    end
    check("wrap_wide", instret, 64'd16);
    wb_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
